// File: rtl/ysyx_040066_mem_arb_if.sv
// ysyx_040066_mem_arb_if: fetch, data and memory-port signals around the memory arbiter
// master is the arbiter's view; slave is the surrounding pipeline/bus view.
interface ysyx_040066_mem_arb_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_kill;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        d_rd;
    logic        d_wr;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wmask;
    logic [2:0]  d_len;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        d_stall;
    logic        err;
    logic        m_valid;
    logic        m_ready;
    logic        m_wen;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wmask;
    logic [2:0]  m_len;
    logic        m_rvalid;
    logic [63:0] m_rdata;
    logic        m_rerr;
    modport master (
        input  if_req, if_addr, if_kill, d_rd, d_wr, d_addr, d_wdata, d_wmask, d_len,
               m_ready, m_rvalid, m_rdata, m_rerr,
        output if_done, if_rdata, d_done, d_rdata, d_stall, err,
               m_valid, m_wen, m_addr, m_wdata, m_wmask, m_len
    );
    modport slave (
        output if_req, if_addr, if_kill, d_rd, d_wr, d_addr, d_wdata, d_wmask, d_len,
               m_ready, m_rvalid, m_rdata, m_rerr,
        input  if_done, if_rdata, d_done, d_rdata, d_stall, err,
               m_valid, m_wen, m_addr, m_wdata, m_wmask, m_len
    );
endinterface

// File: rtl/ysyx_040066_mem_arb.sv
// ysyx_040066_mem_arb: shares one memory port between fetch and data with data priority,
// a fetch starvation guard, a per-transaction timeout and a fetch-kill path.
module ysyx_040066_mem_arb #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input logic                   clk,
    input logic                   rst,
    ysyx_040066_mem_arb_if.master bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {DATA, INST} owner_t;
    state_t        state, state_nx;
    owner_t        owner;
    logic [SW-1:0] starve;
    logic [TW-1:0] tcnt;
    logic          kill;
    logic          d_req, i_req, starved, grant_d, grant_i, rsp, tout, fin, done_d, done_i;
    always_comb begin
        d_req    = bus.d_rd | bus.d_wr;
        i_req    = bus.if_req & ~bus.if_kill;
        starved  = i_req && starve == SW'(STARVE_MAX);
        grant_d  = state == IDLE && d_req && !starved;
        grant_i  = state == IDLE && i_req && !grant_d;
        rsp      = state == WAIT && bus.m_rvalid;
        tout     = state != IDLE && tcnt == TW'(TIMEOUT) && !rsp;
        fin      = rsp | tout;
        done_d   = fin && owner == DATA;
        done_i   = fin && owner == INST && !kill && !bus.if_kill;
        state_nx = fin ? IDLE :
                   state == IDLE ? ((grant_d | grant_i) ? REQ : IDLE) :
                   (state == REQ && bus.m_ready) ? WAIT : state;
        bus.m_valid  = state == REQ;
        bus.if_done  = done_i;
        bus.d_done   = done_d;
        bus.if_rdata = rsp ? bus.m_rdata : '0;
        bus.d_rdata  = rsp ? bus.m_rdata : '0;
        // a timeout always reports an error; a real response reports the bus error
        bus.err      = (done_i | done_d) & (~rsp | bus.m_rerr);
        bus.d_stall  = d_req & ~done_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= DATA;
            starve      <= '0;
            tcnt        <= '0;
            kill        <= 1'b0;
            bus.m_wen   <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.m_wmask <= '0;
            bus.m_len   <= '0;
        end else begin
            state <= state_nx;
            tcnt  <= state == IDLE ? '0 : tcnt + TW'(1);
            kill  <= state_nx == IDLE ? 1'b0 : kill | (owner == INST && state != IDLE && bus.if_kill);
            if (grant_i || !bus.if_req)
                starve <= '0;
            else if (grant_d && starve != SW'(STARVE_MAX))
                starve <= starve + SW'(1);
            if (grant_d) begin
                owner       <= DATA;
                bus.m_wen   <= bus.d_wr;
                bus.m_addr  <= bus.d_addr;
                bus.m_wdata <= bus.d_wdata;
                bus.m_wmask <= bus.d_wmask;
                bus.m_len   <= bus.d_len;
            end else if (grant_i) begin
                owner       <= INST;
                bus.m_wen   <= 1'b0;
                bus.m_addr  <= bus.if_addr;
                bus.m_wdata <= '0;
                bus.m_wmask <= '0;
                bus.m_len   <= 3'b011;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_040066_mem_arb.sv
// tb_ysyx_040066_mem_arb: directed vector table plus hand sequences for the memory arbiter
module tb_ysyx_040066_mem_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    ysyx_040066_mem_arb_if bus();
    ysyx_040066_mem_arb #(.STARVE_MAX(4), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    // in_b = {if_req, d_rd, d_wr, m_ready, m_rvalid, m_rerr}
    // ex_b = {m_valid, m_wen, if_done, d_done, err, d_stall}
    typedef struct {
        string       name;
        logic [5:0]  in_b;
        logic [63:0] rd;
        logic [5:0]  ex_b;
        logic [63:0] erd;
        logic [63:0] eaddr;
    } vec_t;
    vec_t tv[13];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic smp;
        #3;
    endtask
    task automatic wait_valid(input string name);
        int n = 0;
        smp;
        while (!bus.m_valid && n < 20) begin
            cyc;
            smp;
            n++;
        end
        chk({name, " m_valid"}, 64'(bus.m_valid), 64'(1));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int nd;
        tv[0]  = '{"fetch req",     6'b100000, 64'h0,    6'b000000, 64'h0,    64'h0};
        tv[1]  = '{"fetch m_valid", 6'b100100, 64'h0,    6'b100000, 64'h0,    64'h80000000};
        tv[2]  = '{"fetch resp",    6'b100010, 64'h13,   6'b001000, 64'h13,   64'h80000000};
        tv[3]  = '{"store req",     6'b001000, 64'h0,    6'b000001, 64'h0,    64'h80000000};
        tv[4]  = '{"store m_valid", 6'b001100, 64'h0,    6'b110001, 64'h0,    64'h80001008};
        tv[5]  = '{"store ack",     6'b001010, 64'h0,    6'b010100, 64'h0,    64'h80001008};
        tv[6]  = '{"store idle",    6'b000000, 64'h0,    6'b010000, 64'h0,    64'h80001008};
        tv[7]  = '{"load req",      6'b010000, 64'h0,    6'b010001, 64'h0,    64'h80001008};
        tv[8]  = '{"load no rdy",   6'b010000, 64'h0,    6'b100001, 64'h0,    64'h80001008};
        tv[9]  = '{"load accept",   6'b010100, 64'h0,    6'b100001, 64'h0,    64'h80001008};
        tv[10] = '{"load wait",     6'b010000, 64'h0,    6'b000001, 64'h0,    64'h80001008};
        tv[11] = '{"load err resp", 6'b010011, 64'hDEAD, 6'b000110, 64'hDEAD, 64'h80001008};
        tv[12] = '{"idle rvalid",   6'b000010, 64'hBEEF, 6'b000000, 64'h0,    64'h80001008};
        {bus.if_req, bus.if_kill, bus.d_rd, bus.d_wr, bus.m_ready, bus.m_rvalid, bus.m_rerr} = '0;
        bus.if_addr = 64'h80000000;
        bus.d_addr  = 64'h80001008;
        bus.d_wdata = 64'h1122334455667788;
        bus.d_wmask = 8'h0F;
        bus.d_len   = 3'b010;
        bus.m_rdata = '0;
        repeat (2) cyc;
        smp;
        chk("reset ctl", 64'({bus.m_valid, bus.m_wen, bus.if_done, bus.d_done, bus.err}), 64'(0));
        chk("reset m_addr", bus.m_addr, 64'h0);
        chk("reset m_wdata", bus.m_wdata, 64'h0);
        chk("reset mask/len", 64'({bus.m_wmask, bus.m_len}), 64'(0));
        cyc;
        rst = 1'b0;
        foreach (tv[i]) begin
            {bus.if_req, bus.d_rd, bus.d_wr, bus.m_ready, bus.m_rvalid, bus.m_rerr} = tv[i].in_b;
            bus.m_rdata = tv[i].rd;
            smp;
            chk(tv[i].name, 64'({bus.m_valid, bus.m_wen, bus.if_done, bus.d_done, bus.err, bus.d_stall}),
                64'(tv[i].ex_b));
            chk({tv[i].name, " addr"}, bus.m_addr, tv[i].eaddr);
            if (tv[i].ex_b[3] | tv[i].ex_b[2])
                chk({tv[i].name, " rdata"}, tv[i].ex_b[3] ? bus.if_rdata : bus.d_rdata, tv[i].erd);
            cyc;
        end
        {bus.if_req, bus.d_rd, bus.d_wr, bus.m_ready, bus.m_rvalid, bus.m_rerr} = '0;
        chk("latched wmask", 64'(bus.m_wmask), 64'h0F);
        chk("latched len", 64'(bus.m_len), 64'(3'b010));
        chk("latched wdata", bus.m_wdata, 64'h1122334455667788);
        // contention: fetch held against five loads, fetch forced in after four data grants
        bus.if_addr = 64'h80000100;
        bus.d_addr  = 64'h80002000;
        bus.if_req  = 1'b1;
        bus.d_rd    = 1'b1;
        nd = 0;
        for (int g = 0; g < 6; g++) begin
            wait_valid($sformatf("grant%0d", g));
            chk($sformatf("grant%0d owner", g), bus.m_addr, g == 4 ? 64'h80000100 : 64'h80002000);
            if (g == 3) chk("starve saturated", 64'(dut.starve), 64'(4));
            if (g == 4) chk("starve cleared", 64'(dut.starve), 64'(0));
            bus.m_ready = 1'b1;
            cyc;
            bus.m_ready  = 1'b0;
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = 64'h100 + 64'(g);
            smp;
            chk($sformatf("grant%0d done", g), 64'({bus.if_done, bus.d_done}), g == 4 ? 64'(2'b10) : 64'(2'b01));
            chk($sformatf("grant%0d rdata", g), g == 4 ? bus.if_rdata : bus.d_rdata, 64'h100 + 64'(g));
            cyc;
            bus.m_rvalid = 1'b0;
            if (g == 4) bus.if_req = 1'b0;
            else begin
                nd++;
                if (nd == 5) bus.d_rd = 1'b0;
            end
        end
        // kill in IDLE suppresses the grant
        bus.if_req  = 1'b1;
        bus.if_kill = 1'b1;
        cyc;
        bus.if_req  = 1'b0;
        bus.if_kill = 1'b0;
        smp;
        chk("kill idle no grant", 64'(bus.m_valid), 64'(0));
        cyc;
        // kill an outstanding fetch in WAIT
        bus.if_req = 1'b1;
        wait_valid("kill fetch");
        bus.m_ready = 1'b1;
        cyc;
        bus.m_ready = 1'b0;
        bus.if_kill = 1'b1;
        smp;
        chk("kill pulse", 64'({bus.m_valid, bus.if_done}), 64'(0));
        cyc;
        bus.if_kill = 1'b0;
        bus.if_req  = 1'b0;
        cyc;
        cyc;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 64'h77;
        smp;
        chk("killed resp", 64'({bus.if_done, bus.d_done, bus.err}), 64'(0));
        cyc;
        bus.m_rvalid = 1'b0;
        bus.d_rd     = 1'b1;
        bus.d_addr   = 64'h80003000;
        wait_valid("after kill load");
        chk("after kill addr", bus.m_addr, 64'h80003000);
        bus.m_ready = 1'b1;
        cyc;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 64'hABCD;
        smp;
        chk("after kill done", 64'({bus.if_done, bus.d_done, bus.err}), 64'(3'b010));
        chk("after kill rdata", bus.d_rdata, 64'hABCD);
        cyc;
        bus.m_rvalid = 1'b0;
        bus.d_rd     = 1'b0;
        cyc;
        // timeout in REQ: m_ready never comes
        bus.d_rd = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc;
            bus.m_rvalid = (c == 3);
            smp;
            chk($sformatf("to req c%0d", c), 64'({bus.m_valid, bus.d_done, bus.if_done}), 64'(3'b100));
        end
        cyc;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 64'hFFFF;
        smp;
        chk("timeout done", 64'({bus.m_valid, bus.d_done, bus.err}), 64'(3'b111));
        chk("timeout rdata", bus.d_rdata, 64'h0);
        cyc;
        bus.d_rd     = 1'b0;
        bus.m_rvalid = 1'b1;
        smp;
        chk("late rvalid", 64'({bus.m_valid, bus.d_done, bus.if_done, bus.err}), 64'(0));
        cyc;
        bus.m_rvalid = 1'b0;
        // response and timeout in the same cycle: the response wins
        bus.d_rd = 1'b1;
        cyc;
        bus.m_ready = 1'b1;
        for (int c = 2; c <= 8; c++) begin
            cyc;
            bus.m_ready = 1'b0;
            smp;
            chk($sformatf("to wait c%0d", c), 64'(bus.d_done), 64'(0));
        end
        cyc;
        bus.m_rvalid = 1'b1;
        bus.m_rerr   = 1'b0;
        bus.m_rdata  = 64'h55;
        smp;
        chk("rvalid beats timeout", 64'({bus.d_done, bus.err}), 64'(2'b10));
        chk("rvalid beats rdata", bus.d_rdata, 64'h55);
        cyc;
        bus.m_rvalid = 1'b0;
        bus.d_rd     = 1'b0;
        cyc;
        // asynchronous reset in the middle of WAIT
        bus.if_req = 1'b1;
        wait_valid("rst fetch");
        bus.m_ready = 1'b1;
        cyc;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 64'h99;
        smp;
        chk("pre rst done", 64'(bus.if_done), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async rst ctl", 64'({bus.m_valid, bus.if_done, bus.d_done, bus.err}), 64'(0));
        chk("async rst addr", bus.m_addr, 64'h0);
        cyc;
        rst = 1'b0;
        bus.if_req = 1'b0;
        smp;
        chk("post rst rvalid", 64'({bus.m_valid, bus.if_done, bus.d_done}), 64'(0));
        cyc;
        bus.m_rvalid = 1'b0;
        smp;
        chk("post rst idle", 64'(bus.m_valid), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
